hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Hazard/forwarding unit for the 5-stage MIPS pipeline, extended with a multi-cycle multiply/divide (MD) unit that owns HI/LO.
- Keeps the existing forwarding, load-use and branch-compare stall logic.
- Adds:
  - an MD busy scoreboard: a down-counter tracking the in-flight MD operation, stalling dependent MFHI/MFLO and back-to-back MD ops;
  - a branch-taken decode flush;
  - a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register address width.
- MD_LATENCY, 8, cycles an MD op occupies the unit after leaving E (range 1..255).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Branch_D, PcSrc_D  in  1 each  branch in decode / branch taken.
- MdStart_D, MdStart_E  in  1 each  MULT/DIV in decode / in execute.
- HiLoRead_D  in  1  MFHI/MFLO in decode.
- MemToReg_E, RegWrite_E, MemToReg_M, RegWrite_M, RegWrite_W  in  1 each  pipeline control.
- Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W  in  REG_W each  register addresses.
- Stall_F, Stall_D, Flush_D, Flush_E  out  1 each  pipeline control.
- ForwardA_D, ForwardB_D  out  1 each  decode comparator forward from M.
- ForwardA_E, ForwardB_E  out  2 each  ALU operand mux: 00 regfile, 01 from W, 10 from M.
- MdBusy  out  1  MD unit occupied.
- StallCount  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding (combinational):
  - ForwardA_E = 10 if Rs_E≠0 && Rs_E==WriteReg_M && RegWrite_M; else 01 if Rs_E≠0 && Rs_E==WriteReg_W && RegWrite_W; else 00. M takes priority over W.
  - ForwardB_E: same rule using Rt_E.
  - ForwardA_D = Rs_D≠0 && Rs_D==WriteReg_M && RegWrite_M. ForwardB_D: same with Rt_D.
- LWStall = MemToReg_E && WriteReg_E≠0 && (WriteReg_E==Rs_D || WriteReg_E==Rt_D).
- BranchStall = Branch_D && ((RegWrite_E && WriteReg_E≠0 && WriteReg_E∈{Rs_D,Rt_D}) || (MemToReg_M && WriteReg_M≠0 && WriteReg_M∈{Rs_D,Rt_D})).
- MD scoreboard:
  - State: 8-bit md_cnt, MdBusy = (md_cnt≠0).
  - MdStart_E in a cycle → md_cnt loads MD_LATENCY at next edge.
  - Otherwise, if md_cnt≠0, decrement by 1 each cycle.
  - MdStart_E while busy (only possible after an external error) → reload MD_LATENCY; no error flag.
  - HI/LO valid from the cycle MdBusy falls.
- MdStall = (HiLoRead_D || MdStart_D) && (MdBusy || MdStart_E). This covers the op currently in E, whose count has not yet loaded.
- Stall = LWStall || BranchStall || MdStall.
  - Stall_F = Stall_D = Flush_E = Stall. All combinational; zero latency.
- Flush_D = PcSrc_D && !Stall_D. A stalled branch must not flush its own delay fetch.
- StallCount increments each cycle Stall=1 and saturates at all-ones; it never wraps.
- Reset (synchronous, evaluated every edge):
  - md_cnt=0 and StallCount=0 at the next edge.
  - Reset mid-MD operation abandons the op; MdBusy=0 the cycle after reset.
  - Outputs during and after reset follow the combinational equations from the held inputs. With all inputs 0, every output is 0.
- Simultaneous events:
  - LW and MD stall together → one stall cycle counted, not two.
  - MdStart_E with reset → reset wins.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_ZERO=5'd0;
  - default MD_LATENCY.
- One natural sub-module: md_scoreboard (md_cnt counter, MdBusy). Forwarding and stall equations stay in the top.

Test Plan:
- ADD $3 in M (RegWrite_M=1, WriteReg_M=3), Rs_E=3, also WriteReg_W=3 → ForwardA_E=10. With WriteReg_M=0 and Rs_E=0 → ForwardA_E=00.
- LW $5 in E (MemToReg_E=1, WriteReg_E=5), Rt_D=5 → Stall_F/Stall_D/Flush_E=1 for one cycle, StallCount +1. Repeat with WriteReg_E=0 → no stall.
- BEQ in D (Branch_D=1, Rs_D=7), RegWrite_E=1, WriteReg_E=7 → stall; next cycle instruction in M → ForwardA_D=1, no stall. PcSrc_D=1 then gives Flush_D=1 only when not stalled.
- MdStart_E pulse, MD_LATENCY=8, then HiLoRead_D held → MdBusy high exactly 8 cycles, stall for 9 cycles (E cycle plus 8), StallCount=9.
- Reset asserted at MD count 4 → MdBusy=0 next cycle, StallCount=0, HiLoRead_D no longer stalls.
- Force 2^CNT_W stall cycles (CNT_W=4 build) → StallCount stops at 15.

Source files
------------

// File: rtl/hazard_unit_mc_pkg.sv
// hazard_unit_mc_pkg: shared forwarding encodings, register constants and MD defaults
package hazard_unit_mc_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_LATENCY_DEF = 8;
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: pipeline-to-hazard-unit control and address bundle
interface hazard_unit_mc_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic Branch_D, PcSrc_D, MdStart_D, MdStart_E, HiLoRead_D;
  logic MemToReg_E, RegWrite_E, MemToReg_M, RegWrite_M, RegWrite_W;
  logic [REG_W-1:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic Stall_F, Stall_D, Flush_D, Flush_E;
  logic ForwardA_D, ForwardB_D;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic MdBusy;
  logic [CNT_W-1:0] StallCount;
  modport master (
    output Branch_D, PcSrc_D, MdStart_D, MdStart_E, HiLoRead_D,
    output MemToReg_E, RegWrite_E, MemToReg_M, RegWrite_M, RegWrite_W,
    output Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
    input Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_D, ForwardB_D,
    input ForwardA_E, ForwardB_E, MdBusy, StallCount
  );
  modport slave (
    input Branch_D, PcSrc_D, MdStart_D, MdStart_E, HiLoRead_D,
    input MemToReg_E, RegWrite_E, MemToReg_M, RegWrite_M, RegWrite_W,
    input Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
    output Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_D, ForwardB_D,
    output ForwardA_E, ForwardB_E, MdBusy, StallCount
  );
endinterface

// File: rtl/hazard_unit_mc_md_scoreboard.sv
// hazard_unit_mc_md_scoreboard: down-counter tracking occupancy of the multiply/divide unit
module hazard_unit_mc_md_scoreboard
  import hazard_unit_mc_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);
  logic [7:0] md_cnt;
  // load on an op leaving E (a restart while busy simply reloads), else count down to idle
  always_ff @(posedge clk)
    md_cnt <= reset ? 8'd0 : start ? 8'(MD_LATENCY) : (md_cnt != 8'd0) ? md_cnt - 8'd1 : md_cnt;
  assign busy = md_cnt != 8'd0;
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use/branch/MD stall detection and stall-cycle counter
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  hazard_unit_mc_if.slave hz
);
  localparam logic [REG_W-1:0] ZR = REG_W'(REG_ZERO);
  logic md_busy, lw_stall, br_stall, md_stall, stall;
  logic e_hits_d, m_hits_d;
  logic [CNT_W-1:0] stall_cnt;
  hazard_unit_mc_md_scoreboard #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk(clk),
    .reset(reset),
    .start(hz.MdStart_E),
    .busy(md_busy)
  );
  // stall sources; an MD op still in E counts as busy because its count has not loaded yet
  always_comb begin
    e_hits_d = hz.WriteReg_E != ZR && (hz.WriteReg_E == hz.Rs_D || hz.WriteReg_E == hz.Rt_D);
    m_hits_d = hz.WriteReg_M != ZR && (hz.WriteReg_M == hz.Rs_D || hz.WriteReg_M == hz.Rt_D);
    lw_stall = hz.MemToReg_E && e_hits_d;
    br_stall = hz.Branch_D && ((hz.RegWrite_E && e_hits_d) || (hz.MemToReg_M && m_hits_d));
    md_stall = (hz.HiLoRead_D || hz.MdStart_D) && (md_busy || hz.MdStart_E);
    stall = lw_stall || br_stall || md_stall;
  end
  // operand forwarding; M is the newer result so it wins over W
  always_comb begin
    hz.ForwardA_E = fwd_sel(hz.Rs_E != ZR && hz.Rs_E == hz.WriteReg_M && hz.RegWrite_M,
                            hz.Rs_E != ZR && hz.Rs_E == hz.WriteReg_W && hz.RegWrite_W);
    hz.ForwardB_E = fwd_sel(hz.Rt_E != ZR && hz.Rt_E == hz.WriteReg_M && hz.RegWrite_M,
                            hz.Rt_E != ZR && hz.Rt_E == hz.WriteReg_W && hz.RegWrite_W);
    hz.ForwardA_D = hz.Rs_D != ZR && hz.Rs_D == hz.WriteReg_M && hz.RegWrite_M;
    hz.ForwardB_D = hz.Rt_D != ZR && hz.Rt_D == hz.WriteReg_M && hz.RegWrite_M;
  end
  // pipeline control; a stalled branch keeps its delay-slot fetch
  always_comb begin
    hz.Stall_F = stall;
    hz.Stall_D = stall;
    hz.Flush_E = stall;
    hz.Flush_D = hz.PcSrc_D && !stall;
    hz.MdBusy = md_busy;
    hz.StallCount = stall_cnt;
  end
  // count stalled cycles once each, holding at all-ones
  always_ff @(posedge clk)
    stall_cnt <= reset ? '0 : (stall && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: table-driven and sequence checks of hazard_unit_mc
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic reset, reset4;
  int tests = 0;
  int fails = 0;
  hazard_unit_mc_if #(.REG_W(5), .CNT_W(32)) hz ();
  hazard_unit_mc_if #(.REG_W(5), .CNT_W(4)) hz4 ();
  hazard_unit_mc #(.REG_W(5), .MD_LATENCY(8), .CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(hz));
  hazard_unit_mc #(.REG_W(5), .MD_LATENCY(8), .CNT_W(4)) dut4 (.clk(clk), .reset(reset4), .hz(hz4));
  always #5 clk = ~clk;
  typedef struct {
    logic br, pc, mdd, mde, hlr, m2re, rwe, m2rm, rwm, rww;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic st, fd, fad, fbd;
    logic [1:0] fae, fbe;
  } vec_t;
  vec_t v [19];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t t);
    hz.Branch_D = t.br; hz.PcSrc_D = t.pc; hz.MdStart_D = t.mdd; hz.MdStart_E = t.mde;
    hz.HiLoRead_D = t.hlr; hz.MemToReg_E = t.m2re; hz.RegWrite_E = t.rwe;
    hz.MemToReg_M = t.m2rm; hz.RegWrite_M = t.rwm; hz.RegWrite_W = t.rww;
    hz.Rs_D = t.rsd; hz.Rt_D = t.rtd; hz.Rs_E = t.rse; hz.Rt_E = t.rte;
    hz.WriteReg_E = t.wre; hz.WriteReg_M = t.wrm; hz.WriteReg_W = t.wrw;
  endtask
  task automatic clear();
    apply('{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] outs();
    return 32'({hz.Stall_F, hz.Stall_D, hz.Flush_E, hz.Flush_D, hz.ForwardA_D, hz.ForwardB_D,
                hz.ForwardA_E, hz.ForwardB_E});
  endfunction
  initial begin
    int nb, nst;
    v[0]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    v[1]  = '{0,0,0,0,0,0,0,0,1,1, 0,0,3,0,0,3,3, 0,0,0,0,2'd2,2'd0};
    v[2]  = '{0,0,0,0,0,0,0,0,1,1, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    v[3]  = '{0,0,0,0,0,0,0,0,1,1, 0,0,4,4,0,6,4, 0,0,0,0,2'd1,2'd1};
    v[4]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,4,0,0,4,4, 0,0,0,0,2'd0,2'd0};
    v[5]  = '{0,0,0,0,0,1,0,0,0,0, 0,5,0,0,5,0,0, 1,0,0,0,2'd0,2'd0};
    v[6]  = '{0,0,0,0,0,1,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    v[7]  = '{1,1,0,0,0,0,1,0,0,0, 7,0,0,0,7,0,0, 1,0,0,0,2'd0,2'd0};
    v[8]  = '{1,1,0,0,0,0,0,0,1,0, 7,0,0,0,0,7,0, 0,1,1,0,2'd0,2'd0};
    v[9]  = '{1,0,0,0,0,0,0,1,1,0, 0,9,0,0,0,9,0, 1,0,0,1,2'd0,2'd0};
    v[10] = '{0,0,0,0,0,0,0,0,1,0, 0,2,0,2,0,2,0, 0,0,0,1,2'd0,2'd2};
    v[11] = '{0,0,0,1,1,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,2'd0,2'd0};
    v[12] = '{0,0,1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,2'd0,2'd0};
    v[13] = '{0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    v[14] = '{0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0,2'd0,2'd0};
    v[15] = '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    v[16] = '{1,0,0,0,0,0,0,0,0,0, 7,0,0,0,7,0,0, 0,0,0,0,2'd0,2'd0};
    v[17] = '{0,0,0,0,0,1,0,0,0,0, 8,0,0,0,8,0,0, 1,0,0,0,2'd0,2'd0};
    v[18] = '{1,0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
    reset = 1'b1;
    reset4 = 1'b1;
    clear();
    hz4.Branch_D = 0; hz4.PcSrc_D = 0; hz4.MdStart_D = 0; hz4.MdStart_E = 0; hz4.HiLoRead_D = 0;
    hz4.MemToReg_E = 1; hz4.RegWrite_E = 0; hz4.MemToReg_M = 0; hz4.RegWrite_M = 0; hz4.RegWrite_W = 0;
    hz4.Rs_D = 0; hz4.Rt_D = 5; hz4.Rs_E = 0; hz4.Rt_E = 0;
    hz4.WriteReg_E = 5; hz4.WriteReg_M = 0; hz4.WriteReg_W = 0;
    step();
    #1;
    chk("reset_outs_zero", outs(), 32'd0);
    for (int i = 0; i < 19; i++) begin
      apply(v[i]);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          32'({v[i].st, v[i].st, v[i].st, v[i].fd, v[i].fad, v[i].fbd, v[i].fae, v[i].fbe}));
      step();
    end
    clear();
    step();
    chk("reset_count", hz.StallCount, 32'd0);
    chk("reset_busy", 32'(hz.MdBusy), 32'd0);
    reset = 1'b0;
    hz.MemToReg_E = 1; hz.WriteReg_E = 5; hz.Rt_D = 5;
    #1;
    chk("lw_stall", 32'({hz.Stall_F, hz.Stall_D, hz.Flush_E}), 32'd7);
    step();
    clear();
    #1;
    chk("lw_count", hz.StallCount, 32'd1);
    chk("lw_released", 32'(hz.Stall_D), 32'd0);
    hz.Branch_D = 1; hz.PcSrc_D = 1; hz.Rs_D = 7; hz.RegWrite_E = 1; hz.WriteReg_E = 7;
    #1;
    chk("br_stall_noflush", 32'({hz.Stall_D, hz.Flush_D}), 32'b10);
    step();
    hz.RegWrite_E = 0; hz.WriteReg_E = 0; hz.RegWrite_M = 1; hz.WriteReg_M = 7;
    #1;
    chk("br_fwd_flush", 32'({hz.Stall_D, hz.ForwardA_D, hz.Flush_D}), 32'b011);
    step();
    clear();
    #1;
    chk("br_count", hz.StallCount, 32'd2);
    hz.MdStart_E = 1; hz.HiLoRead_D = 1;
    #1;
    chk("md_e_stall", 32'(hz.Stall_D), 32'd1);
    nst = 1;
    nb = 0;
    step();
    hz.MdStart_E = 0;
    #1;
    while (hz.MdBusy && nb < 20) begin
      nb++;
      if (hz.Stall_D) nst++;
      step();
    end
    chk("md_busy_cycles", 32'(nb), 32'd8);
    chk("md_stall_cycles", 32'(nst), 32'd9);
    chk("md_hilo_valid", 32'(hz.Stall_D), 32'd0);
    chk("md_count", hz.StallCount, 32'd11);
    hz.MdStart_E = 1; hz.HiLoRead_D = 1; hz.MemToReg_E = 1; hz.WriteReg_E = 5; hz.Rt_D = 5;
    step();
    clear();
    #1;
    chk("lw_md_single_count", hz.StallCount, 32'd12);
    chk("md_reload_busy", 32'(hz.MdBusy), 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("md_busy_at4", 32'(hz.MdBusy), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_md_busy", 32'(hz.MdBusy), 32'd0);
    chk("rst_mid_md_count", hz.StallCount, 32'd0);
    reset = 1'b0;
    hz.HiLoRead_D = 1;
    #1;
    chk("rst_hilo_nostall", 32'(hz.Stall_D), 32'd0);
    step();
    hz.HiLoRead_D = 0;
    reset = 1'b1;
    hz.MdStart_E = 1;
    step();
    reset = 1'b0;
    hz.MdStart_E = 0;
    #1;
    chk("rst_beats_start", 32'(hz.MdBusy), 32'd0);
    chk("sat_held", 32'(hz4.StallCount), 32'd0);
    reset4 = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sat_10", 32'(hz4.StallCount), 32'd10);
    for (int i = 0; i < 5; i++) step();
    chk("sat_15", 32'(hz4.StallCount), 32'd15);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold", 32'(hz4.StallCount), 32'd15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
